// File: rtl/multicycle_control_unit.sv
// Purpose : Moore-FSM sequencer for the ARM-subset multicycle datapath (ADD/SUB/MOV/CMP/LDR/STR/B/BL),
//           owns the NZCV flags register and evaluates the condition code of each instruction.
// Latency : outputs decode combinationally from state + Instr; 2..5 cycles per instruction.
// Backpr. : none; the sequencer never stalls and the datapath follows every cycle.
//
// Ports:
//   clk, reset (async, active-high)   - clock and reset (reset forces FETCH, clears flags, masks writes)
//   Instr[31:0], ALUFlags[3:0]        - instruction register contents, combinational {N,Z,C,V} from ALU
//   PCWrite, IRWrite, MemWrite,
//   RegWrite, LinkWrite               - write enables (forced low while reset is high)
//   AdrSrc, ResultSrc, ALUControl,
//   ALUSrcA, ALUSrcB, ImmSrc, RegSrc  - datapath mux selects
//   State[3:0]                        - current state encoding (debug)
//
// Build option: define COND_FULL_EN to evaluate all ARM condition codes; otherwise only EQ/NE/AL.

module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic        LinkWrite,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;

    logic [1:0] w_op;
    logic [3:0] w_funct;
    logic       w_is_add, w_is_sub, w_is_mov, w_is_cmp;
    logic       w_writes_rd;
    logic       w_flag_upd;
    logic       w_cond_ex;
    logic [1:0] w_dp_alu;
    logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_link_write;
    logic       w_unused;

    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[24:21];
    assign w_is_add = (w_funct == 4'b0100);
    assign w_is_sub = (w_funct == 4'b0010);
    assign w_is_mov = (w_funct == 4'b1101);
    assign w_is_cmp = (w_funct == 4'b1010);
    assign w_writes_rd = w_is_add | w_is_sub | w_is_mov;

    // Flags load on the edge leaving EXEC: always for CMP, for ADD/SUB only with S set.
    assign w_flag_upd = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                        (w_is_cmp || (Instr[20] && (w_is_add || w_is_sub)));

    // Only the fields the sequencer decodes are consumed; register numbers and immediates are datapath business.
    assign w_unused = ^{Instr[19:0], r_flags};

    always_comb begin
        w_cond_ex = 1'b0;
`ifdef COND_FULL_EN
        case (Instr[31:28])
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = ~r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = ~r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = ~r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
`else
        case (Instr[31:28])
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = ~r_flags[2];
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
`endif
    end

    // Unsupported DP opcodes keep add so the ALU is quiet; they retire with no writes.
    always_comb begin
        w_dp_alu = 2'b00;
        if (w_is_sub || w_is_cmp) w_dp_alu = 2'b01;
        else if (w_is_mov)        w_dp_alu = 2'b10;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_cond_ex) begin
                    case (w_op)
                        2'b00:   w_next = Instr[25] ? S_EXECI : S_EXECR;
                        2'b01:   w_next = S_MEMADR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: w_next = w_writes_rd ? S_ALUWB : S_FETCH;
            S_MEMADR:  w_next = Instr[20] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_flag_upd) r_flags <= ALUFlags;
        end
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_link_write = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUControl   = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ImmSrc       = 2'b00;
        RegSrc       = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_pc_write = 1'b1;
                w_ir_write = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                // PC+4 again here so R15 reads see PC+8.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = {(w_op == 2'b01) && !Instr[20], (w_op == 2'b10)};
                ImmSrc    = (w_op == 2'b01) ? 2'b01 : ((w_op == 2'b10) ? 2'b10 : 2'b00);
            end
            S_EXECR: ALUControl = w_dp_alu;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_alu;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = Instr[23] ? 2'b00 : 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                RegSrc      = 2'b10;
            end
            S_BRANCH: begin
                ALUSrcB      = 2'b01;
                ImmSrc       = 2'b10;
                ResultSrc    = 2'b10;
                w_pc_write   = 1'b1;
                w_link_write = Instr[24];
            end
            default: ;
        endcase
    end

    // Reset drops the state to FETCH asynchronously; masking the enables prevents any partial write.
    assign PCWrite   = w_pc_write   & ~reset;
    assign IRWrite   = w_ir_write   & ~reset;
    assign MemWrite  = w_mem_write  & ~reset;
    assign RegWrite  = w_reg_write  & ~reset;
    assign LinkWrite = w_link_write & ~reset;
    assign State     = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, LinkWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  State;

    typedef struct packed {
        logic       pcw;
        logic       adrsrc;
        logic       memw;
        logic       irw;
        logic [1:0] ressrc;
        logic [1:0] aluctl;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] immsrc;
        logic       regw;
        logic       linkw;
        logic [1:0] regsrc;
    } ctrl_t;

    ctrl_t dut_ctrl;
    assign dut_ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                       ALUSrcA, ALUSrcB, ImmSrc, RegWrite, LinkWrite, RegSrc};

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .LinkWrite(LinkWrite), .RegSrc(RegSrc),
        .State(State)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0] flags_m;     // model of the architectural NZCV register
    int         exp_q[$];    // expected state per cycle for the current instruction
    int         seen_st[$];
    ctrl_t      seen_ctrl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ARM condition semantics.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
`ifdef COND_FULL_EN
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
`else
        if (c == 4'd0)  return z;
        if (c == 4'd1)  return !z;
        if (c == 4'd14) return 1'b1;
        return 1'b0;
`endif
    endfunction

    // Instruction-level path: which states the instruction visits, from its fields.
    task automatic build_path(input logic [31:0] ins, output bit upd);
        logic [3:0] fn;
        fn  = ins[24:21];
        upd = 1'b0;
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(1);
        if (cond_ok(ins[31:28], flags_m)) begin
            case (ins[27:26])
                2'b00: begin
                    exp_q.push_back(ins[25] ? 7 : 6);
                    if (fn == 4'b0100 || fn == 4'b0010 || fn == 4'b1101) exp_q.push_back(8);
                    upd = (fn == 4'b1010) || (ins[20] && (fn == 4'b0100 || fn == 4'b0010));
                end
                2'b01: begin
                    exp_q.push_back(2);
                    if (ins[20]) begin exp_q.push_back(3); exp_q.push_back(4); end
                    else exp_q.push_back(5);
                end
                2'b10: exp_q.push_back(9);
                default: ;
            endcase
        end
    endtask

    // Control word required in each state.
    function automatic ctrl_t exp_ctrl(input int st, input logic [31:0] ins);
        ctrl_t c;
        logic [3:0] fn;
        fn = ins[24:21];
        c  = '0;
        case (st)
            0: begin c.pcw = 1; c.irw = 1; c.srca = 1; c.srcb = 2'b10; c.ressrc = 2'b10; end
            1: begin
                c.srca = 1; c.srcb = 2'b10; c.ressrc = 2'b10;
                c.regsrc[0] = (ins[27:26] == 2'b10);
                c.regsrc[1] = (ins[27:26] == 2'b01) && !ins[20];
                c.immsrc = (ins[27:26] == 2'b01) ? 2'b01 : (ins[27:26] == 2'b10) ? 2'b10 : 2'b00;
            end
            2: begin c.srcb = 2'b01; c.immsrc = 2'b01; c.aluctl = ins[23] ? 2'b00 : 2'b01; end
            3: c.adrsrc = 1;
            4: begin c.ressrc = 2'b01; c.regw = 1; end
            5: begin c.adrsrc = 1; c.memw = 1; c.regsrc = 2'b10; end
            6, 7: begin
                c.srcb = (st == 7) ? 2'b01 : 2'b00;
                if (fn == 4'b0010 || fn == 4'b1010) c.aluctl = 2'b01;
                else if (fn == 4'b1101)            c.aluctl = 2'b10;
            end
            8: c.regw = 1;
            9: begin c.srcb = 2'b01; c.immsrc = 2'b10; c.ressrc = 2'b10; c.pcw = 1; c.linkw = ins[24]; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c = exp_ctrl(0, 32'd0);
        c.pcw = 0;
        c.irw = 0;
        return c;
    endfunction

    // Called just after a rising edge with the DUT in FETCH. limit>0 stops at the negedge of that cycle.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] ef, input int limit);
        bit upd;
        build_path(ins, upd);
        seen_st.delete();
        seen_ctrl.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            Instr    = (k == 0) ? $urandom : ins;
            ALUFlags = (exp_q[k] == 6 || exp_q[k] == 7) ? ef : 4'($urandom);
            @(negedge clk);
            seen_st.push_back(int'(State));
            seen_ctrl.push_back(dut_ctrl);
            chk("state", 32'(State), 32'(exp_q[k]));
            chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(exp_q[k], ins)));
            if (limit > 0 && k == limit - 1) return;
            @(posedge clk);
            #1;
        end
        if (upd) flags_m = ef;
    endtask

    // Hex-digit trace with a leading 1 as length sentinel, e.g. states 0,1,7,8 -> 'h10178.
    task automatic chk_seq(input string nm, input logic [31:0] exp);
        logic [31:0] acc;
        acc = 32'd1;
        foreach (seen_st[i]) acc = (acc << 4) | 32'(seen_st[i]);
        chk(nm, acc, exp);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int p;
        r = $urandom;
        p = $urandom_range(0, 5);
        case (p)
            0: r[31:28] = 4'd0;
            1: r[31:28] = 4'd1;
            2, 3, 4: r[31:28] = 4'd14;
            default: ;
        endcase
        r[27:26] = 2'($urandom_range(0, 3));
        if (r[27:26] == 2'b00) begin
            p = $urandom_range(0, 4);
            case (p)
                0: r[24:21] = 4'b0100;
                1: r[24:21] = 4'b0010;
                2: r[24:21] = 4'b1101;
                3: r[24:21] = 4'b1010;
                default: ;
            endcase
        end
        return r;
    endfunction

    localparam logic [31:0] ADD_I  = 32'hE2821005;
    localparam logic [31:0] CMP_R  = 32'hE1510001;
    localparam logic [31:0] BEQ    = 32'h0A000002;
    localparam logic [31:0] BNE    = 32'h1A000002;
    localparam logic [31:0] STR_N  = 32'hE5043008;
    localparam logic [31:0] BL     = 32'hEB000010;
    localparam logic [31:0] LDR_P  = 32'hE5943000;
    localparam logic [31:0] ADD_GE = 32'hA2821005;
    localparam logic [31:0] ADD_EQ = 32'h02821005;

    initial begin
        reset    = 1'b1;
        Instr    = 32'd0;
        ALUFlags = 4'd0;
        flags_m  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_ctrl", 32'(dut_ctrl), 32'(reset_ctrl()));
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(ADD_I, 4'($urandom), 0);
        chk_seq("add_seq", 32'h10178);
        chk("add_execi_srcb", 32'(seen_ctrl[2].srcb), 32'd1);
        chk("add_wb_regw", 32'({seen_ctrl[2].regw, seen_ctrl[3].regw}), 32'b01);

        run_instr(CMP_R, 4'b0100, 0);
        chk_seq("cmp_seq", 32'h1016);
        run_instr(BEQ, 4'($urandom), 0);
        chk_seq("beq_taken_seq", 32'h1019);
        chk("beq_pcw", 32'(seen_ctrl[2].pcw), 32'd1);
        run_instr(CMP_R, 4'b0100, 0);
        run_instr(BNE, 4'($urandom), 0);
        chk_seq("bne_skip_seq", 32'h101);

        run_instr(STR_N, 4'($urandom), 0);
        chk_seq("str_seq", 32'h10125);
        chk("str_memadr_sub", 32'(seen_ctrl[2].aluctl), 32'b01);
        chk("str_memwrite", 32'({seen_ctrl[3].memw, seen_ctrl[3].regsrc}), 32'b110);

        run_instr(BL, 4'($urandom), 0);
        chk_seq("bl_seq", 32'h1019);
        chk("bl_branch", 32'({seen_ctrl[2].pcw, seen_ctrl[2].linkw, seen_ctrl[2].immsrc}), 32'b1110);

        run_instr(CMP_R, 4'b1000, 0);
        run_instr(ADD_GE, 4'($urandom), 0);
        chk_seq("ge_skip_seq", 32'h101);
        run_instr(CMP_R, 4'b0100, 0);
        run_instr(ADD_EQ, 4'($urandom), 0);
        chk_seq("eq_exec_seq", 32'h10178);

        // Z set, then reset lands in MEMREAD of an LDR: flags must clear.
        run_instr(CMP_R, 4'b0100, 0);
        run_instr(LDR_P, 4'($urandom), 4);
        chk_seq("ldr_partial_seq", 32'h10123);
        reset = 1'b1;
        flags_m = 4'd0;
        #1;
        chk("midrst_state", 32'(State), 32'd0);
        chk("midrst_ctrl", 32'(dut_ctrl), 32'(reset_ctrl()));
        @(posedge clk);
        #1;
        chk("midrst_hold_ctrl", 32'(dut_ctrl), 32'(reset_ctrl()));
        reset = 1'b0;
        run_instr(BEQ, 4'($urandom), 0);
        chk_seq("post_rst_beq_seq", 32'h101);
        run_instr(LDR_P, 4'($urandom), 0);
        chk_seq("ldr_seq", 32'h101234);

        for (int n = 0; n < 500; n++) begin
            run_instr(rand_instr(), 4'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
